// File: rtl/logic_arb_pkg.sv
// ---------------------------------------------------------------------------
// logic_arb_pkg
//   Shared definitions for the boolean-op arbiter slice:
//   - 2-bit operation codes understood by logic_op_unit
//   - state encoding of the arbiter FSM
// ---------------------------------------------------------------------------
package logic_arb_pkg;

    localparam logic [1:0] OP_AND     = 2'd0;
    localparam logic [1:0] OP_OR      = 2'd1;
    localparam logic [1:0] OP_NOT_IN1 = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/logic_op_unit.sv
// ---------------------------------------------------------------------------
// logic_op_unit
//   Combinational bitwise boolean datapath shared by all requesters.
//   Ports:
//     in1, in2 : operands (WIDTH bits)
//     op       : operation code (AND / OR / NOT_IN1 / reserved)
//     result   : bitwise result; zero for the reserved code
//     err      : high when op is the reserved code
// ---------------------------------------------------------------------------
module logic_op_unit
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    // Decode the operation; anything not recognised yields zero and flags an error.
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            OP_AND:     result = in1 & in2;
            OP_OR:      result = in1 | in2;
            OP_NOT_IN1: result = ~in1;
            OP_RSVD: begin
                result = '0;
                err    = 1'b1;
            end
            default: begin
                result = '0;
                err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// ---------------------------------------------------------------------------
// logic_op_arbiter
//   Round-robin arbiter sharing one logic_op_unit among N_REQ requesters with
//   a REQ/DONE handshake; one operation in flight at a time (IDLE->EXEC->RESP).
//   Ports:
//     CLK, RST  : clock (rising edge), asynchronous active-high reset
//     REQ       : request per requester, held until its DONE bit
//     OP        : 2-bit op per requester (packed, requester i at [2i+:2])
//     IN1, IN2  : operands per requester (packed, requester i at [WIDTH*i+:WIDTH])
//     GNT       : one-hot grant, high in EXEC and RESP
//     DONE      : one-hot completion pulse in RESP
//     RESULT    : result, held until the next completion
//     ERR       : pulses with DONE when the granted op was the reserved code
//     BUSY      : high in EXEC and RESP
//     GNT_CNT   : per-requester saturating grant counters (CNT_W each)
//   Optional feature: define LOGIC_ARB_STATS_EN to build the grant counters;
//   otherwise GNT_CNT is tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module logic_op_arbiter
    import logic_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [2*N_REQ-1:0]     OP,
    input  logic [WIDTH*N_REQ-1:0] IN1,
    input  logic [WIDTH*N_REQ-1:0] IN2,
    output logic [N_REQ-1:0]       GNT,
    output logic [N_REQ-1:0]       DONE,
    output logic [WIDTH-1:0]       RESULT,
    output logic                   ERR,
    output logic                   BUSY,
    output logic [CNT_W*N_REQ-1:0] GNT_CNT
);

    localparam int PTR_W = $clog2(N_REQ);

    // Index base+offs, wrapping past N_REQ-1 back to 0 (offs < N_REQ).
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int offs);
        int sum_v;
        sum_v = int'(base) + offs;
        if (sum_v >= N_REQ) begin
            sum_v = sum_v - N_REQ;
        end else begin
            sum_v = sum_v;
        end
        return sum_v[PTR_W-1:0];
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    arb_state_e        state_r, state_nx_s;
    logic [PTR_W-1:0]  rr_ptr_r, rr_ptr_nx_s;
    logic [PTR_W-1:0]  win_r, win_nx_s;
    logic [1:0]        op_r, op_nx_s;
    logic [WIDTH-1:0]  in1_r, in1_nx_s;
    logic [WIDTH-1:0]  in2_r, in2_nx_s;
    logic [N_REQ-1:0]  gnt_r, gnt_nx_s;
    logic [N_REQ-1:0]  done_r, done_nx_s;
    logic [WIDTH-1:0]  result_r, result_nx_s;
    logic              err_r, err_nx_s;
    logic              busy_r, busy_nx_s;

    logic              pick_valid_s;
    logic [PTR_W-1:0]  pick_idx_s;
    logic [WIDTH-1:0]  unit_result_s;
    logic              unit_err_s;

    logic_op_unit #(.WIDTH(WIDTH)) u_op_unit (
        .in1    (in1_r),
        .in2    (in2_r),
        .op     (op_r),
        .result (unit_result_s),
        .err    (unit_err_s)
    );

    // Round-robin pick: scan from the pointer downwards so the lowest offset wins.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (REQ[wrap_idx(rr_ptr_r, k)]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = wrap_idx(rr_ptr_r, k);
            end else begin
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_nx_s  = state_r;
        rr_ptr_nx_s = rr_ptr_r;
        win_nx_s    = win_r;
        op_nx_s     = op_r;
        in1_nx_s    = in1_r;
        in2_nx_s    = in2_r;
        gnt_nx_s    = gnt_r;
        done_nx_s   = '0;
        result_nx_s = result_r;
        err_nx_s    = 1'b0;
        busy_nx_s   = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    // Operands are captured here so later input changes are ignored.
                    win_nx_s   = pick_idx_s;
                    op_nx_s    = OP[2*int'(pick_idx_s) +: 2];
                    in1_nx_s   = IN1[WIDTH*int'(pick_idx_s) +: WIDTH];
                    in2_nx_s   = IN2[WIDTH*int'(pick_idx_s) +: WIDTH];
                    gnt_nx_s   = one_hot(pick_idx_s);
                    busy_nx_s  = 1'b1;
                    state_nx_s = ST_EXEC;
                end else begin
                    gnt_nx_s   = '0;
                    busy_nx_s  = 1'b0;
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                result_nx_s = unit_result_s;
                err_nx_s    = unit_err_s;
                done_nx_s   = one_hot(win_r);
                state_nx_s  = ST_RESP;
            end
            ST_RESP: begin
                gnt_nx_s    = '0;
                busy_nx_s   = 1'b0;
                rr_ptr_nx_s = wrap_idx(win_r, 1);
                state_nx_s  = ST_IDLE;
            end
            default: begin
                gnt_nx_s   = '0;
                busy_nx_s  = 1'b0;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer, operand latches and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            win_r    <= '0;
            op_r     <= 2'd0;
            in1_r    <= '0;
            in2_r    <= '0;
            gnt_r    <= '0;
            done_r   <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            rr_ptr_r <= rr_ptr_nx_s;
            win_r    <= win_nx_s;
            op_r     <= op_nx_s;
            in1_r    <= in1_nx_s;
            in2_r    <= in2_nx_s;
            gnt_r    <= gnt_nx_s;
            done_r   <= done_nx_s;
            result_r <= result_nx_s;
            err_r    <= err_nx_s;
            busy_r   <= busy_nx_s;
        end
    end

    assign GNT    = gnt_r;
    assign DONE   = done_r;
    assign RESULT = result_r;
    assign ERR    = err_r;
    assign BUSY   = busy_r;

`ifdef LOGIC_ARB_STATS_EN
    logic grant_evt_s;
    assign grant_evt_s = (state_r == ST_IDLE) && pick_valid_s;

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        logic [CNT_W-1:0] cnt_r;

        // Saturating count of grants to requester g; cleared only by reset.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                cnt_r <= '0;
            end else if (grant_evt_s && (pick_idx_s == PTR_W'(g)) &&
                         (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end

        assign GNT_CNT[g*CNT_W +: CNT_W] = cnt_r;
    end
`else
    assign GNT_CNT = '0;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_op_arbiter
//   Directed self-checking bench for logic_op_arbiter (N_REQ=4, WIDTH=4,
//   CNT_W=2). Grant-counter expectations follow LOGIC_ARB_STATS_EN.
//   Requester setup (IN1 / IN2 / OP -> result):
//     r0: 1100 / 1010 / AND -> 1000     r1: 0101 / 0010 / OR  -> 0111
//     r2: 0011 / 1111 / NOT -> 1100     r3: 1001 / 0110 / OR  -> 1111
// ---------------------------------------------------------------------------
module tb_logic_op_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [7:0]  OP;
    logic [15:0] IN1;
    logic [15:0] IN2;
    logic [3:0]  GNT;
    logic [3:0]  DONE;
    logic [3:0]  RESULT;
    logic        ERR;
    logic        BUSY;
    logic [7:0]  GNT_CNT;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] exp_win [5];
    logic [3:0] exp_res [5];
    logic [7:0] exp_cnt;

    logic_op_arbiter #(.N_REQ(4), .WIDTH(4), .CNT_W(2)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .OP      (OP),
        .IN1     (IN1),
        .IN2     (IN2),
        .GNT     (GNT),
        .DONE    (DONE),
        .RESULT  (RESULT),
        .ERR     (ERR),
        .BUSY    (BUSY),
        .GNT_CNT (GNT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        exp_win = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_res = '{4'b0111, 4'b1100, 4'b1111, 4'b1000, 4'b0111};
        RST = 1'b1;
        REQ = 4'b0000;
        OP  = 8'h64;
        IN1 = 16'h935C;
        IN2 = 16'h6F2A;
        step();
        step();
        RST = 1'b0;
        step();

        // Reset state
        check("rst_gnt",    GNT,     64'd0);
        check("rst_done",   DONE,    64'd0);
        check("rst_result", RESULT,  64'd0);
        check("rst_err",    ERR,     64'd0);
        check("rst_busy",   BUSY,    64'd0);
        check("rst_cnt",    GNT_CNT, 64'd0);

        // Single request from r0: grant at t+1, done at t+2
        REQ = 4'b0001;
        step();
        check("t1_gnt",  GNT,  64'h1);
        check("t1_busy", BUSY, 64'd1);
        check("t1_done0", DONE, 64'd0);
        step();
        check("t1_done",   DONE,   64'h1);
        check("t1_result", RESULT, 64'h8);
        check("t1_err",    ERR,    64'd0);
        REQ = 4'b0000;
        step();
        check("t1_idle_gnt",  GNT,    64'd0);
        check("t1_idle_busy", BUSY,   64'd0);
        check("t1_idle_done", DONE,   64'd0);
        check("t1_hold_res",  RESULT, 64'h8);

        // All requesting: pointer is at 1, so order 1,2,3,0,1 with DONE every 3 cycles
        REQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_gnt", GNT, 64'(exp_win[i]));
            step();
            check("t2_done",   DONE,   64'(exp_win[i]));
            check("t2_result", RESULT, 64'(exp_res[i]));
            if (i == 4) REQ = 4'b0000;
            step();
            check("t2_idle_done", DONE, 64'd0);
            check("t2_idle_busy", BUSY, 64'd0);
        end

        // Reserved op on r2 (pointer now 2)
        OP  = 8'h74;
        REQ = 4'b0100;
        step();
        check("t3_gnt", GNT, 64'h4);
        step();
        check("t3_done",   DONE,   64'h4);
        check("t3_result", RESULT, 64'h0);
        check("t3_err",    ERR,    64'd1);
        REQ = 4'b0000;
        step();
        check("t3_err_pulse", ERR, 64'd0);
        OP  = 8'h64;
        REQ = 4'b0100;
        step();
        step();
        check("t3_done2",   DONE,   64'h4);
        check("t3_result2", RESULT, 64'hC);
        check("t3_err2",    ERR,    64'd0);
        REQ = 4'b0000;
        step();

        // Reset during EXEC of r3: op lost, pointer back to 0
        REQ = 4'b1000;
        step();
        check("t4_gnt", GNT, 64'h8);
        RST = 1'b1;
        REQ = 4'b0000;
        #1;
        check("t4_async_gnt",  GNT,  64'd0);
        check("t4_async_busy", BUSY, 64'd0);
        step();
        check("t4_done",   DONE,    64'd0);
        check("t4_result", RESULT,  64'd0);
        check("t4_cnt",    GNT_CNT, 64'd0);
        RST = 1'b0;
        REQ = 4'b1010;
        step();
        check("t4_first_gnt", GNT, 64'h2);
        step();
        check("t4_first_done", DONE,   64'h2);
        check("t4_first_res",  RESULT, 64'h7);
        REQ = 4'b1000;
        step();
        step();
        check("t4_second_gnt", GNT, 64'h8);
        step();
        check("t4_second_done", DONE,   64'h8);
        check("t4_second_res",  RESULT, 64'hF);
        REQ = 4'b0000;
        step();

        // Operands latched at grant; REQ dropped in EXEC still completes
        REQ = 4'b0001;
        step();
        check("t5_gnt", GNT, 64'h1);
        IN1 = 16'h935F;
        OP  = 8'h65;
        REQ = 4'b0000;
        step();
        check("t5_done",   DONE,   64'h1);
        check("t5_result", RESULT, 64'h8);
        step();
        IN1 = 16'h935C;
        OP  = 8'h64;

        // Five more grants to r0 (six since reset) -> counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            REQ = 4'b0001;
            step();
            step();
            check("t6_done", DONE, 64'h1);
            REQ = 4'b0000;
            step();
        end
`ifdef LOGIC_ARB_STATS_EN
        exp_cnt = 8'b01_00_01_11;
`else
        exp_cnt = 8'b00_00_00_00;
`endif
        check("t6_gnt_cnt", GNT_CNT, 64'(exp_cnt));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
